// File: rtl/mem_req_pkg.sv
// Shared types and lane helpers for the 64-bit block memory request initiator.
package mem_req_pkg;
  localparam int BLK_W  = 64;
  localparam int WORD_W = 16;
  localparam int LANES  = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    DONE
  } state_t;

  // Word 0 sits in the least significant 16 bits of the block.
  function automatic logic [WORD_W-1:0] lane_sel(input logic [BLK_W-1:0] blk,
                                                 input logic [$clog2(LANES)-1:0] idx);
    return blk[idx*WORD_W +: WORD_W];
  endfunction

  function automatic logic [BLK_W-1:0] lane_merge(input logic [BLK_W-1:0] blk,
                                                  input logic [$clog2(LANES)-1:0] idx,
                                                  input logic [WORD_W-1:0] word);
    logic [BLK_W-1:0] res;
    res = blk;
    res[idx*WORD_W +: WORD_W] = word;
    return res;
  endfunction
endpackage

// File: rtl/mem_req_init_timer.sv
// Saturating response timer: counts enabled cycles up to limit, hit while at limit.
// Zero limit disables it (count held at 0, hit never asserts); clear has priority.
module req_timer #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr || (limit == '0)) begin
      cnt <= '0;
    end else if (en && (cnt != limit)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (limit != '0) && (cnt == limit);
endmodule

// File: rtl/mem_req_init.sv
// Word-to-block memory initiator; reads take 3+k cycles, writes (read-modify-write) 5+2k.
// No backpressure: cpuReq is only sampled in IDLE, hung memory is cut off by the timeout.
module mem_req_init
  import mem_req_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 11
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cpuReq,
  input  logic               cpuWr,
  input  logic [15:0]        cpuAddr,
  input  logic [WORD_W-1:0]  cpuWData,
  output logic [WORD_W-1:0]  cpuRData,
  output logic               cpuDone,
  output logic               cpuBusy,
  output logic               memErr,
  output logic               startReq,
  output logic [15:0]        inAddr,
  output logic               isRd,
  output logic [BLK_W-1:0]   inData,
  input  logic [BLK_W-1:0]   outData,
  input  logic               reqFinish
);
  localparam logic [CNT_W-1:0] TIMER_LIMIT = CNT_W'(TIMEOUT_CYC);

  state_t             state;
  logic               accWr;
  logic [1:0]         accIdx;
  logic [WORD_W-1:0]  accWData;
  logic               timerHit;
  logic               timerClr;
  logic               timerEn;
  logic               unusedAddrLsb;

  // Byte address bit 0 does not affect lane selection.
  assign unusedAddrLsb = cpuAddr[0];

  assign timerClr = (state == RD_REQ) || (state == WR_REQ);
  assign timerEn  = ((state == RD_WAIT) || (state == WR_WAIT)) && !reqFinish;

  req_timer #(
    .CNT_W(CNT_W)
  ) uTimer (
    .clk  (clk),
    .rstn (rstn),
    .clr  (timerClr),
    .en   (timerEn),
    .limit(TIMER_LIMIT),
    .hit  (timerHit)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      accWr    <= 1'b0;
      accIdx   <= '0;
      accWData <= '0;
      cpuRData <= '0;
      cpuDone  <= 1'b0;
      cpuBusy  <= 1'b0;
      memErr   <= 1'b0;
      startReq <= 1'b0;
      inAddr   <= '0;
      isRd     <= 1'b1;
      inData   <= '0;
    end else begin
      cpuDone  <= 1'b0;
      startReq <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpuReq) begin
            accWr    <= cpuWr;
            accIdx   <= cpuAddr[2:1];
            accWData <= cpuWData;
            inAddr   <= {cpuAddr[15:3], 3'b000};
            isRd     <= 1'b1;
            startReq <= 1'b1;
            cpuBusy  <= 1'b1;
            state    <= RD_REQ;
          end
        end
        RD_REQ: state <= RD_WAIT;
        RD_WAIT: begin
          // A finish in the limit cycle wins over the timeout.
          if (reqFinish) begin
            if (accWr) begin
              inData   <= lane_merge(outData, accIdx, accWData);
              isRd     <= 1'b0;
              startReq <= 1'b1;
              state    <= WR_REQ;
            end else begin
              cpuRData <= lane_sel(outData, accIdx);
              state    <= DONE;
            end
          end else if (timerHit) begin
            memErr <= 1'b1;
            if (!accWr) begin
              cpuRData <= '0;
            end
            state <= DONE;
          end
        end
        WR_REQ: state <= WR_WAIT;
        WR_WAIT: begin
          if (reqFinish) begin
            state <= DONE;
          end else if (timerHit) begin
            memErr <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          cpuDone <= 1'b1;
          isRd    <= 1'b1;
          cpuBusy <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_req_init.sv
// Scoreboard bench for mem_req_init: a behavioural memory answers block requests,
// a word-level reference model predicts every completion.
module tb_mem_req_init;
  localparam int T = 8;

  typedef struct {
    bit          rd;
    logic [15:0] data;
    bit          err;
    int          due;
  } exp_t;

  typedef struct {
    bit          rd;
    logic [15:0] addr;
    logic [63:0] data;
  } req_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cpuReq, cpuWr;
  logic [15:0] cpuAddr, cpuWData, cpuRData;
  logic        cpuDone, cpuBusy, memErr, startReq, isRd, reqFinish;
  logic [15:0] inAddr;
  logic [63:0] inData, outData;

  logic [63:0] mem    [0:8191];
  logic [63:0] refMem [0:8191];
  exp_t        expQ[$];
  req_t        reqQ[$];
  int          cyc = 0;
  int          memLat = 1;
  int          rstEpoch = 0;
  int          strayCnt = 0;
  int          strayDone = 0;
  bit          refErr = 1'b0;
  int          total = 0;
  int          bad = 0;

  mem_req_init #(.TIMEOUT_CYC(T), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn), .cpuReq(cpuReq), .cpuWr(cpuWr), .cpuAddr(cpuAddr),
    .cpuWData(cpuWData), .cpuRData(cpuRData), .cpuDone(cpuDone), .cpuBusy(cpuBusy),
    .memErr(memErr), .startReq(startReq), .inAddr(inAddr), .isRd(isRd),
    .inData(inData), .outData(outData), .reqFinish(reqFinish)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_cpuRData"}, 64'(cpuRData), 64'h0);
    check({tag, "_cpuDone"},  64'(cpuDone),  64'h0);
    check({tag, "_cpuBusy"},  64'(cpuBusy),  64'h0);
    check({tag, "_memErr"},   64'(memErr),   64'h0);
    check({tag, "_startReq"}, 64'(startReq), 64'h0);
    check({tag, "_inAddr"},   64'(inAddr),   64'h0);
    check({tag, "_isRd"},     64'(isRd),     64'h1);
    check({tag, "_inData"},   inData,        64'h0);
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (cpuBusy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cpuBusy) begin
      total++;
      bad++;
      $display("FAIL waitIdle: cpuBusy still 1 after %0d cycles, required 0", n);
    end
  endtask

  // Word-level model: a block is four 16-bit words, word i at bits 16i and up.
  task automatic doAccess(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                          input int lat, input bit expDone);
    int          blk, idx, lcy;
    bit          ans;
    logic [63:0] nb;
    logic [15:0] rdv;
    exp_t        e;
    req_t        r;
    waitIdle();
    blk    = int'(addr >> 3);
    idx    = int'(addr[2:1]);
    ans    = (lat > 0) && (lat <= T);
    memLat = lat;
    r.rd   = 1'b1;
    r.addr = addr & 16'hFFF8;
    r.data = 64'h0;
    reqQ.push_back(r);
    rdv = (ans && !wr) ? 16'(refMem[blk] >> (16 * idx)) : 16'h0;
    if (wr && ans) begin
      nb = (refMem[blk] & ~(64'hFFFF << (16 * idx))) | (64'(wd) << (16 * idx));
      r.rd   = 1'b0;
      r.data = nb;
      reqQ.push_back(r);
      refMem[blk] = nb;
    end
    if (!ans) refErr = 1'b1;
    lcy = !ans ? 3 + T : (wr ? 5 + 2 * lat : 3 + lat);
    e = '{rd: !wr, data: rdv, err: refErr, due: cyc + 1 + lcy};
    if (expDone) expQ.push_back(e);
    cpuWr    = wr;
    cpuAddr  = addr;
    cpuWData = wd;
    cpuReq   = 1'b1;
    @(negedge clk);
    cpuReq   = 1'b0;
    cpuAddr  = 16'($urandom);
    cpuWData = 16'($urandom);
  endtask

  // Behavioural memory: answers k cycles after it samples startReq, commits writes on answer.
  initial begin
    bit          sRd;
    logic [15:0] sAddr;
    logic [63:0] sData;
    int          ep, lat;
    req_t        r;
    reqFinish = 1'b0;
    outData   = 64'h0;
    forever begin
      @(posedge clk);
      if (strayCnt != strayDone) begin
        strayDone++;
        #1 reqFinish = 1'b1;
        outData = {$urandom, $urandom};
        @(posedge clk);
        #1 reqFinish = 1'b0;
      end else if (startReq) begin
        sRd = isRd; sAddr = inAddr; sData = inData; ep = rstEpoch; lat = memLat;
        if (reqQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected startReq: isRd=%0b inAddr=%h, required none", sRd, sAddr);
        end else begin
          r = reqQ.pop_front();
          check("req_isRd", 64'(sRd), 64'(r.rd));
          check("req_inAddr", 64'(sAddr), 64'(r.addr));
          if (!r.rd) check("req_inData", sData, r.data);
        end
        if (lat != 0) begin
          repeat (lat) @(posedge clk);
          #1;
          if (ep == rstEpoch) begin
            check("stable_inAddr", 64'(inAddr), 64'(sAddr));
            check("stable_isRd", 64'(isRd), 64'(sRd));
            check("stable_inData", inData, sData);
          end
          if (sRd) begin
            outData = mem[sAddr[15:3]];
          end else begin
            mem[sAddr[15:3]] = sData;
            outData = {$urandom, $urandom};
          end
          reqFinish = 1'b1;
          @(posedge clk);
          #1 reqFinish = 1'b0;
        end
      end
    end
  end

  // Completion monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cpuDone) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected cpuDone at cycle %0d, required none", cyc);
        end else begin
          e = expQ.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.due));
          if (e.rd) check("cpuRData", 64'(cpuRData), 64'(e.data));
          check("memErr", 64'(memErr), 64'(e.err));
        end
      end
    end
  end

  initial begin
    #400000;
    total++;
    bad++;
    $display("FAIL watchdog: run did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n;
    rstn = 1'b0; cpuReq = 1'b0; cpuWr = 1'b0; cpuAddr = 16'h0; cpuWData = 16'h0;
    for (int i = 0; i < 8192; i++) begin
      mem[i]    = (i < 16) ? {$urandom, $urandom} : 64'h0;
      refMem[i] = mem[i];
    end
    mem[2] = 64'h4444_3333_2222_1111;
    refMem[2] = mem[2];
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Randomized traffic on blocks 4..11, no timeouts.
    for (int i = 0; i < 24; i++) begin
      doAccess(1'($urandom_range(0, 1)), 16'($urandom_range(32, 95)), 16'($urandom),
               $urandom_range(1, 5), 1'b1);
    end

    // Basic read, RMW write and read-back.
    doAccess(1'b0, 16'h0014, 16'h0, 2, 1'b1);
    doAccess(1'b1, 16'h0016, 16'hABCD, 3, 1'b1);
    doAccess(1'b0, 16'h0016, 16'h0, 1, 1'b1);

    // Lane edges and the ignored address LSB.
    doAccess(1'b1, 16'h0000, 16'h0001, 2, 1'b1);
    doAccess(1'b1, 16'h0006, 16'h8000, 1, 1'b1);
    doAccess(1'b0, 16'h0001, 16'h0, 1, 1'b1);
    doAccess(1'b0, 16'h0002, 16'h0, 2, 1'b1);
    doAccess(1'b0, 16'h0004, 16'h0, 3, 1'b1);
    doAccess(1'b0, 16'h0007, 16'h0, 1, 1'b1);

    // Stray reqFinish in IDLE.
    waitIdle();
    strayCnt++;
    repeat (6) @(negedge clk);
    check("stray_cpuBusy", 64'(cpuBusy), 64'h0);

    // Answer exactly in the limit cycle is a success.
    doAccess(1'b0, 16'h0014, 16'h0, T, 1'b1);
    doAccess(1'b1, 16'h0024, 16'h5A5A, T, 1'b1);
    doAccess(1'b0, 16'h0024, 16'h0, 2, 1'b1);

    // Timeouts, then sticky memErr on later good accesses.
    doAccess(1'b0, 16'h0030, 16'h0, 0, 1'b1);
    doAccess(1'b1, 16'h0032, 16'h1234, 0, 1'b1);
    doAccess(1'b0, 16'h0032, 16'h0, 2, 1'b1);
    doAccess(1'b1, 16'h0034, 16'h7777, 1, 1'b1);

    // Reset while the write half of an RMW is outstanding.
    doAccess(1'b1, 16'h0048, 16'hBEEF, 6, 1'b0);
    n = 0;
    while (!(cpuBusy && !isRd && !startReq) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reached_wr_wait", 64'(cpuBusy && !isRd && !startReq), 64'h1);
    #2 rstn = 1'b0;
    rstEpoch++;
    #1;
    checkResetOutputs("midreset");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    refErr = 1'b0;
    repeat (15) @(negedge clk);
    check("post_reset_idle", 64'(cpuBusy), 64'h0);
    doAccess(1'b0, 16'h004A, 16'h0, 3, 1'b1);
    doAccess(1'b0, 16'h0048, 16'h0, 1, 1'b1);

    waitIdle();
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(expQ.size()), 64'h0);
    check("requests_drained", 64'(reqQ.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
